mem_arbiter: RTL

Shares the single unified main memory between the instruction-cache fill path and the data-cache fill/writeback path. Each side raises a request and holds it. The arbiter picks one owner, issues the access, waits for completion, then returns read data with a one-cycle done pulse. It sits between the two caches and the four-bank memory, and is the only master on the memory port.

---
 rtl/mem_arb_defs.sv | 14 +
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_defs.sv
// Shared definitions for the memory arbiter: FSM state encodings and owner codes.
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request picker: a lone requester wins; ties go to D in priority mode,
// otherwise to the side that was not granted last.
module rr_arb2
  import mem_arb_defs::*;
(
  input  logic [1:0] req_i,     // [0] = I side, [1] = D side
  input  logic       last_i,    // side granted last time
  input  logic       prio_d_i,  // 1 = D always wins a tie
  output logic       grant_c_o
);

  // Combinational winner selection
  always_comb begin
    grant_c_o = OWNER_I;
    case (req_i)
      2'b01:   grant_c_o = OWNER_I;
      2'b10:   grant_c_o = OWNER_D;
      2'b11:   grant_c_o = prio_d_i ? OWNER_D : ~last_i;
      default: grant_c_o = OWNER_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified main memory between the I-cache fill path and
// the D-cache fill/writeback path. One access in flight at a time.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter bit          D_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  // data side
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic              owner
);

  arb_state_e        state_q;
  logic              owner_q;   // also serves as the round-robin last-grant pointer
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              i_done_q;
  logic              d_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              grant_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_d;
  logic              load_en;
  logic              cap_en;

  rr_arb2 u_pick (
    .req_i     ({d_req, i_req}),
    .last_i    (owner_q),
    .prio_d_i  (D_PRIORITY),
    .grant_c_o (grant_d)
  );

  // Winner's request fields and datapath load enables
  always_comb begin
    addr_d  = (grant_d == OWNER_D) ? d_addr : i_addr;
    wr_d    = (grant_d == OWNER_D) ? d_wr : 1'b0;
    load_en = (state_q == ST_IDLE) && (i_req || d_req);
    cap_en  = (state_q == ST_WAIT) && mem_done;
  end

  // Arbitration FSM with registered strobes, done pulses and owner
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_I;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner_q  <= grant_d;
            mem_rd_q <= ~wr_d;
            mem_wr_q <= wr_d;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!mem_stall) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_done) begin
            i_done_q <= (owner_q == OWNER_I);
            d_done_q <= (owner_q == OWNER_D);
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Latched request fields and captured read data
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (load_en) begin
        addr_q  <= addr_d;
        wdata_q <= d_wdata;
        wr_q    <= wr_d;
      end
      if (cap_en && (owner_q == OWNER_I)) i_rdata_q <= mem_rdata;
      if (cap_en && (owner_q == OWNER_D)) d_rdata_q <= mem_rdata;
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_q ? wdata_q : wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
